controle_temporizador: RTL and testbench

Moore controller that sequences a `contador_m` instance as a per-round response timer. It clears and enables the counter for each round and watches its `fim`/`meio` flags. It ends the sequence either after `RODADAS` successful plays or on the first timeout. It sits between the game's top-level control unit and the shared timing counter and is the only driver of that counter's `zera_s`/`conta`.

---
 rtl/controle_temporizador.sv | 72 +++++++
 tb/tb_controle_temporizador.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_temporizador.sv
// controle_temporizador: Moore sequencer for a contador_m round timer (ports: clock, reset, iniciar, pausar, jogada, fim_cont, meio_cont -> zera_cont, conta_cont, alerta, timeout, pronto, rodada, db_estado; optional pause via CONTROLE_TEMPORIZADOR_PAUSA_EN)
module controle_temporizador #(
  parameter int RODADAS  = 4,
  parameter int RODADA_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                pausar,
  input  logic                jogada,
  input  logic                fim_cont,
  input  logic                meio_cont,
  output logic                zera_cont,
  output logic                conta_cont,
  output logic                alerta,
  output logic                timeout,
  output logic                pronto,
  output logic [RODADA_W-1:0] rodada,
  output logic [3:0]          db_estado
);
  typedef enum logic [3:0] {
    s_inicial    = 4'd0,
    s_preparacao = 4'd1,
    s_espera     = 4'd2,
    s_pausa      = 4'd3,
    s_registra   = 4'd4,
    s_concluido  = 4'd5,
    s_esgotado   = 4'd6
  } estado_t;
  estado_t estado, prox;
  logic ultima;
  assign ultima = rodada == RODADA_W'(RODADAS - 1);
`ifndef CONTROLE_TEMPORIZADOR_PAUSA_EN
  logic unused_pausar;
  assign unused_pausar = pausar;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= s_inicial;
      rodada <= '0;
      alerta <= 1'b0;
    end else begin
      estado <= prox;
      if (estado == s_registra && prox == s_preparacao) rodada <= rodada + 1'b1;
      else if (prox == s_preparacao) rodada <= '0;
      // alerta is cleared on entry to preparacao so it already reads 0 there
      alerta <= (prox == s_preparacao) ? 1'b0 : (estado == s_espera && meio_cont) ? 1'b1 : alerta;
    end
  end
  always_comb begin
    prox = s_inicial;
    case (estado)
      s_inicial:    prox = iniciar ? s_preparacao : s_inicial;
      s_preparacao: prox = s_espera;
`ifdef CONTROLE_TEMPORIZADOR_PAUSA_EN
      s_espera:     prox = jogada ? s_registra : fim_cont ? s_esgotado : pausar ? s_pausa : s_espera;
      s_pausa:      prox = pausar ? s_pausa : s_espera;
`else
      s_espera:     prox = jogada ? s_registra : fim_cont ? s_esgotado : s_espera;
`endif
      s_registra:   prox = ultima ? s_concluido : s_preparacao;
      s_concluido:  prox = iniciar ? s_preparacao : s_concluido;
      s_esgotado:   prox = iniciar ? s_preparacao : s_esgotado;
      default:      prox = s_inicial;
    endcase
  end
  assign zera_cont  = estado == s_preparacao;
  assign conta_cont = estado == s_espera;
  assign pronto     = estado == s_concluido;
  assign timeout    = estado == s_esgotado;
  assign db_estado  = estado;
endmodule

// File: tb/tb_controle_temporizador.sv
// tb_controle_temporizador: scoreboard bench for controle_temporizador driving a modulo-100 counter model
module tb_controle_temporizador;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 1'b0;
  logic pausar = 1'b0;
  logic jogada = 1'b0;
  logic fim_cont, meio_cont, zera_cont, conta_cont, alerta, timeout, pronto;
  logic [3:0] rodada, db_estado;
  logic [6:0] q;
  logic [12:0] sb[$];
  logic [12:0] e;
  int n_cmp = 0;
  int n_err = 0;

  controle_temporizador #(.RODADAS(4), .RODADA_W(4)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar), .jogada(jogada),
    .fim_cont(fim_cont), .meio_cont(meio_cont), .zera_cont(zera_cont), .conta_cont(conta_cont),
    .alerta(alerta), .timeout(timeout), .pronto(pronto), .rodada(rodada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= '0;
    else if (zera_cont) q <= '0;
    else if (conta_cont) q <= (q == 7'd99) ? 7'd0 : q + 7'd1;
  end
  assign fim_cont  = q == 7'd99;
  assign meio_cont = q == 7'd50;

  function automatic logic [12:0] pk(input logic [3:0] est, input logic [3:0] rod,
                                     input logic a, input logic t, input logic p,
                                     input logic z, input logic c);
    return {est, rod, a, t, p, z, c};
  endfunction

  function automatic logic [12:0] obs();
    return {db_estado, rodada, alerta, timeout, pronto, zera_cont, conta_cont};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    tick(2);
    sb.push_back(pk(0, 0, 0, 0, 0, 0, 0));
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL reset: got %b want %b", obs(), e); end
    reset = 1'b0;
    sb.push_back(pk(0, 0, 0, 0, 0, 0, 0));
    tick(2);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL idle: got %b want %b", obs(), e); end
  endtask

  task automatic test_start();
    iniciar = 1'b1;
    sb.push_back(pk(1, 0, 0, 0, 0, 1, 0));
    tick();
    iniciar = 1'b0;
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL start_prep: got %b want %b", obs(), e); end
    sb.push_back(pk(2, 0, 0, 0, 0, 0, 1));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL start_espera: got %b want %b", obs(), e); end
    n_cmp++;
    if (q !== 7'd0) begin n_err++; $display("FAIL first_espera_q: got %0d want 0", q); end
  endtask

  task automatic test_timeout();
    sb.push_back(pk(2, 0, 0, 0, 0, 0, 1));
    tick(50);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL pre_alerta: got %b want %b", obs(), e); end
    sb.push_back(pk(2, 0, 1, 0, 0, 0, 1));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL alerta: got %b want %b", obs(), e); end
    iniciar = 1'b1;
    sb.push_back(pk(2, 0, 1, 0, 0, 0, 1));
    tick();
    iniciar = 1'b0;
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL iniciar_ignored: got %b want %b", obs(), e); end
    sb.push_back(pk(2, 0, 1, 0, 0, 0, 1));
    tick(47);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL pre_timeout: got %b want %b", obs(), e); end
    sb.push_back(pk(6, 0, 1, 1, 0, 0, 0));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL timeout: got %b want %b", obs(), e); end
    sb.push_back(pk(6, 0, 1, 1, 0, 0, 0));
    tick(3);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL esgotado_hold: got %b want %b", obs(), e); end
  endtask

  task automatic test_rounds();
    iniciar = 1'b1;
    sb.push_back(pk(1, 0, 0, 0, 0, 1, 0));
    tick();
    iniciar = 1'b0;
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL rnd_start_prep: got %b want %b", obs(), e); end
    sb.push_back(pk(2, 0, 0, 0, 0, 0, 1));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL rnd_start_espera: got %b want %b", obs(), e); end
    for (int r = 0; r < 4; r++) begin
      sb.push_back(pk(2, 4'(r), 0, 0, 0, 0, 1));
      tick(9);
      e = sb.pop_front(); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL rnd_wait r=%0d: got %b want %b", r, obs(), e); end
      jogada = 1'b1;
      sb.push_back(pk(4, 4'(r), 0, 0, 0, 0, 0));
      tick();
      jogada = 1'b0;
      e = sb.pop_front(); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL rnd_registra r=%0d: got %b want %b", r, obs(), e); end
      if (r < 3) begin
        sb.push_back(pk(1, 4'(r + 1), 0, 0, 0, 1, 0));
        sb.push_back(pk(2, 4'(r + 1), 0, 0, 0, 0, 1));
        tick();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_err++; $display("FAIL rnd_prep r=%0d: got %b want %b", r, obs(), e); end
        tick();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_err++; $display("FAIL rnd_espera r=%0d: got %b want %b", r, obs(), e); end
      end else begin
        sb.push_back(pk(5, 3, 0, 0, 1, 0, 0));
        tick();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_err++; $display("FAIL rnd_pronto: got %b want %b", obs(), e); end
      end
    end
    sb.push_back(pk(5, 3, 0, 0, 1, 0, 0));
    tick(3);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL pronto_hold: got %b want %b", obs(), e); end
  endtask

  task automatic test_jogada_fim();
    iniciar = 1'b1;
    sb.push_back(pk(1, 0, 0, 0, 0, 1, 0));
    tick();
    iniciar = 1'b0;
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL jf_prep: got %b want %b", obs(), e); end
    sb.push_back(pk(2, 0, 0, 0, 0, 0, 1));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL jf_espera: got %b want %b", obs(), e); end
    sb.push_back(pk(2, 0, 1, 0, 0, 0, 1));
    tick(99);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL jf_before: got %b want %b", obs(), e); end
    n_cmp++;
    if (fim_cont !== 1'b1) begin n_err++; $display("FAIL jf_fim_high: got %b want 1", fim_cont); end
    jogada = 1'b1;
    sb.push_back(pk(4, 0, 1, 0, 0, 0, 0));
    tick();
    jogada = 1'b0;
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL jf_registra: got %b want %b", obs(), e); end
    sb.push_back(pk(1, 1, 0, 0, 0, 1, 0));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL jf_next_prep: got %b want %b", obs(), e); end
    sb.push_back(pk(2, 1, 0, 0, 0, 0, 1));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL jf_next_espera: got %b want %b", obs(), e); end
  endtask

  task automatic test_pause();
    tick(39);
    pausar = 1'b1;
`ifdef CONTROLE_TEMPORIZADOR_PAUSA_EN
    sb.push_back(pk(3, 1, 0, 0, 0, 0, 0));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL pause_enter: got %b want %b", obs(), e); end
    jogada = 1'b1;
    sb.push_back(pk(3, 1, 0, 0, 0, 0, 0));
    tick();
    jogada = 1'b0;
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL pause_jogada: got %b want %b", obs(), e); end
    sb.push_back(pk(3, 1, 0, 0, 0, 0, 0));
    tick(28);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL pause_hold: got %b want %b", obs(), e); end
    n_cmp++;
    if (q !== 7'd40) begin n_err++; $display("FAIL pause_q: got %0d want 40", q); end
    pausar = 1'b0;
    sb.push_back(pk(2, 1, 0, 0, 0, 0, 1));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL pause_exit: got %b want %b", obs(), e); end
    sb.push_back(pk(2, 1, 1, 0, 0, 0, 1));
    tick(59);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL pause_pre_timeout: got %b want %b", obs(), e); end
    sb.push_back(pk(6, 1, 1, 1, 0, 0, 0));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL pause_timeout: got %b want %b", obs(), e); end
`else
    sb.push_back(pk(2, 1, 0, 0, 0, 0, 1));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL nopause_run: got %b want %b", obs(), e); end
    tick(29);
    pausar = 1'b0;
    n_cmp++;
    if (q !== 7'd69) begin n_err++; $display("FAIL nopause_q: got %0d want 69", q); end
    sb.push_back(pk(2, 1, 1, 0, 0, 0, 1));
    tick(30);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL nopause_pre_timeout: got %b want %b", obs(), e); end
    sb.push_back(pk(6, 1, 1, 1, 0, 0, 0));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL nopause_timeout: got %b want %b", obs(), e); end
`endif
  endtask

  task automatic test_reset_mid();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick(10);
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    sb.push_back(pk(2, 1, 0, 0, 0, 0, 1));
    tick(2);
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL rm_round1: got %b want %b", obs(), e); end
    tick(20);
    #2;
    reset = 1'b1;
    #1;
    sb.push_back(pk(0, 0, 0, 0, 0, 0, 0));
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL reset_async: got %b want %b", obs(), e); end
    #1;
    reset = 1'b0;
    tick();
    iniciar = 1'b1;
    sb.push_back(pk(1, 0, 0, 0, 0, 1, 0));
    tick();
    iniciar = 1'b0;
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL restart_prep: got %b want %b", obs(), e); end
    sb.push_back(pk(2, 0, 0, 0, 0, 0, 1));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs() !== e) begin n_err++; $display("FAIL restart_espera: got %b want %b", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_timeout();
    test_rounds();
    test_jogada_fim();
    test_pause();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
